branch_predictor_fsm: RTL and testbench
=======================================

# branch_predictor_fsm

Per-PC branch predictor for the 5-stage RISC-V pipeline, built as a table of 2-bit saturating counters. It sits between IF and EX. IF looks up a taken/not-taken prediction by fetch PC. EX reports each resolved branch, and the block updates the counter, raises a registered mispredict pulse for the flush logic, and keeps branch and miss statistics.

## Interface
Parameters:
- INDEX_BITS, 4, log2 of table depth (16 entries)
- CNT_WIDTH, 16, width of statistics counters

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- if_pc  input  32  PC of the instruction being fetched
- pred_taken  output  1  prediction for if_pc (combinational from table)
- ex_valid  input  1  a branch resolved in EX this cycle
- ex_pc  input  32  PC of the resolved branch
- ex_taken  input  1  actual branch outcome
- ex_pred_taken  input  1  prediction that was issued for this branch in IF
- mispredict  output  1  registered one-cycle pulse, outcome differed from prediction
- branch_count  output  CNT_WIDTH  number of resolved branches since reset
- miss_count  output  CNT_WIDTH  number of mispredictions since reset

## Operation
- Table index:
  - Lookup index = if_pc[INDEX_BITS+1:2].
  - Update index = ex_pc[INDEX_BITS+1:2].
  - pc[1:0] is ignored and upper bits are not tagged, so aliasing is allowed.
- Each entry is a 2-bit FSM:
  - SNT=00, WNT=01, WT=10, ST=11.
  - Taken moves one step toward ST and saturates at ST.
  - Not-taken moves one step toward SNT and saturates at SNT.
- pred_taken = entry[lookup index][1]. It is combinational and has no enable.
- On a rising edge with ex_valid=1:
  - Entry[update index] advances per ex_taken.
  - branch_count increments.
  - If ex_taken != ex_pred_taken, miss_count increments and mispredict is set for the next cycle.
- On a rising edge with ex_valid=0: the table and counters hold, and mispredict is cleared.
- Statistics counters saturate at all-ones. They do not wrap.
- Mispredict detection uses ex_pred_taken only. It does not re-read the table, so earlier aliasing updates do not affect it.

## Timing
- Reset values:
  - All entries = WNT (01).
  - pred_taken = 0 for every PC.
  - mispredict = 0.
  - branch_count = 0 and miss_count = 0.
- reset asserted mid-operation:
  - Outputs go to reset values without waiting for a clock edge.
  - A pending mispredict is dropped.
  - Updates presented while reset is high are ignored.
- Lookup latency is 0 cycles: pred_taken follows if_pc in the same cycle.
- Update latency: a change to an entry is visible on pred_taken from the cycle after the edge that samples ex_valid.
- Mispredict latency is 1 cycle: it is high for exactly the cycle after the edge where ex_valid=1 and the outcome mismatched.
  - Back-to-back mismatching branches produce mispredict high on consecutive cycles, one cycle per event.
- Same-index read/write collision (lookup index equals update index in the same cycle): pred_taken shows the pre-update value. There is no bypass.
- ex_valid=0 with other ex_* inputs changing causes no state change.

## Test plan
- Reset: assert reset asynchronously mid-cycle.
  - Required: mispredict=0, both counters=0 and pred_taken=0 before the next edge.
  - After release, any if_pc gives pred_taken=0.
- Saturation up: 3 updates of ex_pc=0x00000010, ex_taken=1, ex_pred_taken=1.
  - Required: entry 4 goes WNT->WT->ST->ST.
  - pred_taken=1 for if_pc=0x10 from the cycle after the first update.
  - mispredict never asserts, branch_count=3, miss_count=0.
- Mispredict pulse: from reset, ex_pc=0x20, ex_taken=1, ex_pred_taken=0 for one cycle.
  - Required: mispredict=1 for exactly the next cycle, miss_count=1.
  - Entry 8 = WT, so pred_taken for 0x20 = 1.
- Collision: if_pc=ex_pc=0x3C with entry 15=WT, ex_valid=1, ex_taken=0.
  - Required: pred_taken=1 in that cycle and 0 the next cycle (entry WNT).
- Aliasing: update ex_pc=0x04 taken twice (entry ST).
  - Required: if_pc=0x44 gives pred_taken=1 (index 1 shared when INDEX_BITS=4).
- Counter saturation with CNT_WIDTH=4: 20 consecutive mismatching branches.
  - Required: branch_count=miss_count=15, held with no wrap.
  - mispredict high on 20 consecutive cycles.

Source files
------------

// File: rtl/branch_predictor_fsm.sv
// Per-PC branch predictor: a table of 2-bit saturating counters that is looked up by the fetch PC
// and trained by resolved branches from EX. It also produces a registered mispredict pulse and saturating statistics.
module branch_predictor_fsm #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic                 ex_pred_taken,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_t;

  ctr_state_t            table_q [DEPTH];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;

  // Entries are untagged and the word-offset bits are dropped, so distant PCs alias onto the same entry.
  assign lookup_idx = if_pc[INDEX_BITS+1:2];
  assign update_idx = ex_pc[INDEX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0],
                            ex_pc[31:INDEX_BITS+2], ex_pc[1:0]};

  // NOTE: the lookup reads the registered table, so a same-cycle update to the same entry is not forwarded.
  assign pred_taken = table_q[lookup_idx][1];

  function automatic ctr_state_t next_state(input ctr_state_t s, input logic taken);
    ctr_state_t n;
    unique case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the table is only DEPTH small registers, so it is reset like any other flop rather than treated as a RAM.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WNT;
      end
      mispredict   <= 1'b0;
      branch_count <= '0;
      miss_count   <= '0;
    end else begin
      mispredict <= 1'b0;
      if (ex_valid) begin
        table_q[update_idx] <= next_state(table_q[update_idx], ex_taken);
        if (branch_count != '1) begin
          branch_count <= branch_count + CNT_WIDTH'(1);
        end
        // The miss is judged against the prediction IF actually issued, not the current table contents.
        if (ex_taken != ex_pred_taken) begin
          mispredict <= 1'b1;
          if (miss_count != '1) begin
            miss_count <= miss_count + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_fsm.sv
// Scoreboard bench for branch_predictor_fsm. It drives a 16-bit-counter instance and a 4-bit-counter instance in parallel.
module tb_branch_predictor_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic        ex_pred_taken;

  logic        pred_taken, mispredict;
  logic [15:0] branch_count, miss_count;
  logic        pred_taken4, mispredict4;
  logic [3:0]  branch_count4, miss_count4;

  always #5 clk = ~clk;

  branch_predictor_fsm dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .mispredict(mispredict), .branch_count(branch_count), .miss_count(miss_count)
  );

  branch_predictor_fsm #(.INDEX_BITS(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken4),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .mispredict(mispredict4), .branch_count(branch_count4), .miss_count(miss_count4)
  );

  typedef struct {
    logic        mis;
    logic [15:0] bc;
    logic [15:0] mc;
    logic [3:0]  bc4;
    logic [3:0]  mc4;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  m_table [16];
  logic [15:0] m_bc, m_mc;
  logic [3:0]  m_bc4, m_mc4;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_table[i] = 2'b01;
    m_bc = '0; m_mc = '0; m_bc4 = '0; m_mc4 = '0;
  endtask

  task automatic check_pred(input logic [31:0] pc, input string tag);
    if_pc = pc;
    #1;
    check(tag, {31'd0, pred_taken}, {31'd0, m_table[pc[5:2]][1]});
  endtask

  // Called at a negedge: drives one cycle of stimulus and checks pred_taken before the edge.
  // It queues the expected registered outputs, then pops and compares them at the following negedge.
  task automatic apply(input logic v, input logic [31:0] pc, input logic tk,
                       input logic pt, input logic [31:0] ipc);
    exp_t e;
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_pred_taken = pt; if_pc = ipc;
    #1;
    check("pred_pre_edge", {31'd0, pred_taken}, {31'd0, m_table[ipc[5:2]][1]});
    e.mis = 1'b0;
    if (v) begin
      if (tk && m_table[pc[5:2]] != 2'b11) m_table[pc[5:2]] = m_table[pc[5:2]] + 2'd1;
      if (!tk && m_table[pc[5:2]] != 2'b00) m_table[pc[5:2]] = m_table[pc[5:2]] - 2'd1;
      if (m_bc != 16'hFFFF) m_bc++;
      if (m_bc4 != 4'hF) m_bc4++;
      if (tk != pt) begin
        e.mis = 1'b1;
        if (m_mc != 16'hFFFF) m_mc++;
        if (m_mc4 != 4'hF) m_mc4++;
      end
    end
    e.bc = m_bc; e.mc = m_mc; e.bc4 = m_bc4; e.mc4 = m_mc4;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("mispredict",    {31'd0, mispredict},   {31'd0, e.mis});
      check("branch_count",  {16'd0, branch_count}, {16'd0, e.bc});
      check("miss_count",    {16'd0, miss_count},   {16'd0, e.mc});
      check("branch_count4", {28'd0, branch_count4}, {28'd0, e.bc4});
      check("miss_count4",   {28'd0, miss_count4},  {28'd0, e.mc4});
    end
  endtask

  // Called at a negedge: asserts reset mid-cycle and checks that the outputs clear before any edge.
  // It then presents an update while reset is held, which must be ignored.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_mis",  {31'd0, mispredict},   32'd0);
    check("rst_async_bc",   {16'd0, branch_count}, 32'd0);
    check("rst_async_mc",   {16'd0, miss_count},   32'd0);
    check("rst_async_pred", {31'd0, pred_taken},   32'd0);
    ex_valid = 1'b1; ex_pc = 32'h10; ex_taken = 1'b1; ex_pred_taken = 1'b0; if_pc = 32'h10;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_bc",   {16'd0, branch_count}, 32'd0);
    check("rst_hold_mis",  {31'd0, mispredict},   32'd0);
    check("rst_hold_pred", {31'd0, pred_taken},   32'd0);
    ex_valid = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_bc",  {16'd0, branch_count}, 32'd0);
    check("init_mis", {31'd0, mispredict},   32'd0);
    reset = 1'b0;
    check_pred(32'h0000_0000, "reset_pred_0");
    check_pred(32'h0000_0010, "reset_pred_10");
    check_pred(32'hFFFF_FFFC, "reset_pred_top");

    // Saturation toward strongly-taken on entry 4.
    apply(1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
    check_pred(32'h10, "sat_up_first");
    apply(1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
    apply(1'b1, 32'h10, 1'b1, 1'b1, 32'h10);
    check("sat_up_state", {30'd0, dut.table_q[4]}, 32'h3);
    check_pred(32'h10, "sat_up_pred");

    // Single mispredict pulse after a fresh reset.
    do_reset();
    apply(1'b1, 32'h20, 1'b1, 1'b0, 32'h0);
    apply(1'b0, 32'h20, 1'b1, 1'b0, 32'h0);
    check_pred(32'h20, "mis_pulse_pred");

    // A pending pulse is dropped by an asynchronous reset.
    apply(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
    do_reset();

    // Collision: the lookup sees the pre-update entry 15.
    apply(1'b1, 32'h3C, 1'b1, 1'b1, 32'h0);
    apply(1'b1, 32'h3C, 1'b0, 1'b1, 32'h3C);
    check_pred(32'h3C, "collision_after");

    // Aliasing: 0x04 and 0x44 share index 1.
    apply(1'b1, 32'h04, 1'b1, 1'b1, 32'h0);
    apply(1'b1, 32'h04, 1'b1, 1'b1, 32'h0);
    check_pred(32'h44, "alias_pred");

    // Idle cycles with wiggling ex_* inputs must not touch any state.
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, $urandom, 1'($urandom), 1'($urandom), 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      check_pred({$urandom_range(0, 255), 20'd0, i[3:0], 2'($urandom)}, "idle_table");
    end

    // 20 back-to-back mispredicts saturate the 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic tk;
      tk = 1'(i);
      apply(1'b1, {$urandom_range(0, 65535), 10'd0, 4'(i), 2'b00}, tk, ~tk, 32'h0);
    end
    check("sat_bc4_final", {28'd0, branch_count4}, 32'hF);
    check("sat_mc4_final", {28'd0, miss_count4},   32'hF);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
